audio_sample_sequencer: RTL and testbench

Plays a contiguous range of audio samples from sample memory to the DAC/PWM stage at a runtime-selectable sample rate. The block contains its own fractional-rate tick accumulator and a one-entry prefetch buffer. It fetches each sample over a req/ack memory handshake ahead of the sample tick and presents it on a registered output. It sits between the sample RAM/flash controller and the audio output stage, and it counts underruns when memory is too slow.

---
 rtl/audio_sample_sequencer.sv | 95 +++++++++
 tb/tb_audio_sample_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sequencer.sv
// audio_sample_sequencer: streams a sample address range to the audio stage at a programmable rate,
// prefetching each sample over a req/ack handshake and counting missed ticks.
module audio_sample_sequencer #(
  parameter int CLK_HZ = 25000000,
  parameter int RATE_W = 16,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [RATE_W-1:0] rate,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W-1:0] endAddr,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] sample,
  output logic              sampleValid,
  output logic              busy,
  output logic [7:0]        underrunCount
);
  localparam int AW = $clog2(CLK_HZ) + 1;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, STOPPING} state_t;
  state_t state, state_n;
  logic [AW-1:0] acc;
  logic tick, go, last, loop_l;
  logic [RATE_W-1:0] rate_l;
  logic [ADDR_W-1:0] start_l, end_l;
  logic [DATA_W-1:0] buf_q;
  assign go = state == IDLE && start && rate != '0;
  always_comb begin
    state_n = state;
    memReq = state == FETCH || state == STOPPING;
    case (state)
      IDLE:     state_n = go ? FETCH : IDLE;
      FETCH:    state_n = stop ? (memAck ? IDLE : STOPPING) : (memAck ? WAIT : FETCH);
      WAIT:     state_n = stop ? IDLE : !tick ? WAIT : (last && !loop_l) ? IDLE : FETCH;
      STOPPING: state_n = memAck ? IDLE : STOPPING;
      default:  state_n = IDLE;
    endcase
  end
  // busy lags the return to IDLE by one cycle so it falls after the final sampleValid
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      tick <= 1'b0;
      memAddr <= '0;
      sample <= '0;
      sampleValid <= 1'b0;
      busy <= 1'b0;
      underrunCount <= '0;
      buf_q <= '0;
      last <= 1'b0;
      loop_l <= 1'b0;
      rate_l <= '0;
      start_l <= '0;
      end_l <= '0;
    end else begin
      state <= state_n;
      busy <= go || state != IDLE;
      sampleValid <= 1'b0;
      if (go) begin
        acc <= '0;
        tick <= 1'b0;
        rate_l <= rate;
        start_l <= startAddr;
        end_l <= endAddr < startAddr ? startAddr : endAddr;
        loop_l <= loop;
        memAddr <= startAddr;
        underrunCount <= '0;
      end else if (state != IDLE) begin
        acc <= acc >= AW'(CLK_HZ) ? acc - AW'(CLK_HZ) + AW'(rate_l) : acc + AW'(rate_l);
        tick <= acc >= AW'(CLK_HZ);
      end else begin
        tick <= 1'b0;
      end
      if (state == FETCH && tick && underrunCount != 8'hff)
        underrunCount <= underrunCount + 8'd1;
      if (state == FETCH && memAck && !stop) begin
        buf_q <= memData;
        memAddr <= memAddr == end_l ? start_l : memAddr + ADDR_W'(1);
        last <= memAddr == end_l;
      end
      if (state == WAIT && tick && !stop) begin
        sample <= buf_q;
        sampleValid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_audio_sample_sequencer.sv
// tb_audio_sample_sequencer: directed and random playback against an event-level model of the sequencer.
module tb_audio_sample_sequencer;
  localparam int CLK = 100;
  localparam int AW = 18;
  logic clk = 1'b0;
  logic reset, start, stop, loop, memReq, memAck, sampleValid, busy;
  logic [15:0] rate;
  logic [AW-1:0] startAddr, endAddr, memAddr;
  logic [7:0] memData, sample, underrunCount;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] mem [256];
  int lat_a [64];
  int ack_idx, rcnt;
  logic [AW-1:0] ack_q [$];
  int pc_q [$];
  logic [7:0] pv_q [$];
  int ec_q [$];
  logic [7:0] ev_q [$];
  int exp_ur;
  logic [7:0] last_sample;

  audio_sample_sequencer #(.CLK_HZ(CLK), .RATE_W(16), .ADDR_W(AW), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop), .rate(rate),
    .startAddr(startAddr), .endAddr(endAddr), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .sample(sample), .sampleValid(sampleValid),
    .busy(busy), .underrunCount(underrunCount)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // memory model: acks in the lat-th cycle of a request, reset by the same reset
  initial begin
    memAck = 1'b0;
    memData = '0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (reset || !memReq) begin
        memAck = 1'b0;
        rcnt = 0;
      end else begin
        rcnt++;
        if (rcnt >= (ack_idx < 64 ? lat_a[ack_idx] : 1)) begin
          memAck = 1'b1;
          memData = mem[memAddr[7:0]];
          ack_q.push_back(memAddr);
          ack_idx++;
          rcnt = 0;
        end else memAck = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (sampleValid) begin
      pc_q.push_back(cyc);
      pv_q.push_back(sample);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic go_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick(input int sa, input int ea, input int r, input bit lp, output int n);
    @(posedge clk);
    #1;
    pc_q.delete();
    pv_q.delete();
    ack_q.delete();
    ack_idx = 0;
    startAddr = AW'(sa);
    endAddr = AW'(ea);
    rate = 16'(r);
    loop = lp;
    start = 1'b1;
    n = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // the j-th tick after a start in cycle n is high in cycle n + ceil(CLK*j/r) + 2
  function automatic int tick_at(input int n, input int j, input int r);
    return n + (CLK * j + r - 1) / r + 2;
  endfunction

  // each fetch opens the cycle after the previous consume; ticks up to and including
  // its ack cycle are underruns, the first later tick outputs the sample a cycle on
  task automatic model(input int n, input int sa, input int e, input int s, input int r);
    int f, a, j, t, addr;
    ec_q.delete();
    ev_q.delete();
    exp_ur = 0;
    f = n + 1;
    j = 1;
    addr = sa;
    for (int i = 0; i < s; i++) begin
      a = f + lat_a[i] - 1;
      while (tick_at(n, j, r) <= a) begin
        exp_ur++;
        j++;
      end
      t = tick_at(n, j, r);
      j++;
      ec_q.push_back(t + 1);
      ev_q.push_back(mem[addr]);
      addr = addr == e ? sa : addr + 1;
      f = t + 1;
    end
    if (exp_ur > 255) exp_ur = 255;
  endtask

  task automatic play(input int sa, input int ea, input int r, input int lmin, input int lmax, input string tag);
    int n, e, s;
    e = ea < sa ? sa : ea;
    s = e - sa + 1;
    for (int i = 0; i < s; i++) lat_a[i] = $urandom_range(lmax, lmin);
    kick(sa, ea, r, 1'b0, n);
    model(n, sa, e, s, r);
    @(negedge clk);
    chk($sformatf("%s req_after_start", tag), memReq, 1);
    chk($sformatf("%s busy_after_start", tag), busy, 1);
    wait_cyc(ec_q[s-1] + 1);
    chk($sformatf("%s busy_end", tag), busy, 0);
    chk($sformatf("%s valid_end", tag), sampleValid, 0);
    chk($sformatf("%s pulses", tag), pc_q.size(), s);
    for (int i = 0; i < s && i < pc_q.size(); i++) begin
      chk($sformatf("%s pulse%0d_cycle", tag, i), pc_q[i] - n, ec_q[i] - n);
      chk($sformatf("%s pulse%0d_data", tag, i), pv_q[i], ev_q[i]);
    end
    chk($sformatf("%s sample_hold", tag), sample, ev_q[s-1]);
    chk($sformatf("%s underruns", tag), underrunCount, exp_ur);
    last_sample = ev_q[s-1];
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s memReq", tag), memReq, 0);
    chk($sformatf("%s memAddr", tag), memAddr, 0);
    chk($sformatf("%s sample", tag), sample, 0);
    chk($sformatf("%s sampleValid", tag), sampleValid, 0);
    chk($sformatf("%s busy", tag), busy, 0);
    chk($sformatf("%s underrunCount", tag), underrunCount, 0);
  endtask

  initial begin
    int n, t6, sa, len;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop = 1'b0;
    rate = '0;
    startAddr = '0;
    endAddr = '0;
    ack_idx = 0;
    for (int i = 0; i < 64; i++) lat_a[i] = 1;
    for (int i = 0; i < 256; i++) mem[i] = i < 16 ? 8'(i + 16) : 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    play(0, 3, 25, 1, 1, "basic");
    play(0, 3, 50, 5, 5, "underrun");
    play(0, 29, 50, 20, 20, "saturate");
    play(7, 2, 25, 1, 3, "reversed");

    kick(0, 3, 0, 1'b0, n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rate0 busy", busy, 0);
      chk("rate0 req", memReq, 0);
    end

    // loop 5..6, then stop in WAIT exactly on the sixth tick
    for (int i = 0; i < 8; i++) lat_a[i] = 1;
    kick(5, 6, 25, 1'b1, n);
    model(n, 5, 6, 5, 25);
    t6 = tick_at(n, 6, 25);
    go_cyc(t6);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(negedge clk);
    chk("loop stop_idle_req", memReq, 0);
    wait_cyc(t6 + 3);
    chk("loop stop_busy", busy, 0);
    wait_cyc(t6 + 10);
    chk("loop pulses", pc_q.size(), 5);
    for (int i = 0; i < 5 && i < pc_q.size(); i++) begin
      chk($sformatf("loop pulse%0d_cycle", i), pc_q[i] - n, ec_q[i] - n);
      chk($sformatf("loop pulse%0d_data", i), pv_q[i], ev_q[i]);
    end
    chk("loop acks", ack_q.size(), 6);
    for (int i = 0; i < 6 && i < ack_q.size(); i++)
      chk($sformatf("loop ack%0d_addr", i), ack_q[i], i % 2 == 1 ? 6 : 5);
    last_sample = ev_q[4];

    // stop while a request is outstanding; ack lands three cycles later
    lat_a[0] = 5;
    kick(0, 3, 25, 1'b0, n);
    go_cyc(n + 2);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("stopfetch req_c%0d", i), memReq, 1);
    end
    @(negedge clk);
    chk("stopfetch req_drop", memReq, 0);
    wait_cyc(n + 8);
    chk("stopfetch busy", busy, 0);
    chk("stopfetch pulses", pc_q.size(), 0);
    chk("stopfetch sample", sample, last_sample);
    chk("stopfetch acks", ack_q.size(), 1);

    // reset in WAIT with the buffer full
    lat_a[0] = 1;
    kick(0, 3, 25, 1'b0, n);
    go_cyc(n + 3);
    chk("rstwait addr_adv", memAddr, 1);
    chk("rstwait req", memReq, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rstwait");

    // reset in FETCH after underruns have built up
    lat_a[0] = 30;
    kick(0, 3, 50, 1'b0, n);
    wait_cyc(n + 12);
    chk("rstfetch ur_before", underrunCount, 4);
    chk("rstfetch req_before", memReq, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rstfetch");

    for (int k = 0; k < 6; k++) begin
      sa = $urandom_range(200, 0);
      len = $urandom_range(6, 1);
      play(sa, sa + len - 1, $urandom_range(50, 1), 1, 12, $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
